// File: rtl/img_frame_reader.sv
// Frame RAM to mat-stream replay engine, 4 pixels per 64-bit word.
// Optional: IMG_FRAME_READER_BLANK_VALID_EN emits m_valid/!m_de beats in blanking.
module img_frame_reader #(
  parameter int BUF_SIZE   = 640*480,
  parameter int ROWS_BITS  = 9,
  parameter int COLS_BITS  = 10,
  parameter int BLANK_BITS = 8,
  localparam int ADDR_BITS = $clog2(BUF_SIZE) - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic                  start,
  output logic                  busy,
  input  logic [COLS_BITS-1:0]  param_width,
  input  logic [ROWS_BITS-1:0]  param_height,
  input  logic [BLANK_BITS-1:0] param_blank,
  output logic                  rd_en,
  output logic                  rd_regcke,
  output logic [ADDR_BITS-1:0]  rd_addr,
  input  logic [63:0]           rd_dout,
  output logic [ROWS_BITS-1:0]  m_rows,
  output logic [COLS_BITS-1:0]  m_cols,
  output logic                  m_row_first,
  output logic                  m_row_last,
  output logic                  m_col_first,
  output logic                  m_col_last,
  output logic                  m_de,
  output logic [15:0]           m_data,
  output logic                  m_valid
);

  localparam int PIX_BITS = ADDR_BITS + 2;
  localparam logic [PIX_BITS-1:0] PIX_MAX = PIX_BITS'(BUF_SIZE - 1);
`ifdef IMG_FRAME_READER_BLANK_VALID_EN
  localparam logic BLANK_VALID = 1'b1;
`else
  localparam logic BLANK_VALID = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

  typedef struct packed {
    logic       v;
    logic       de;
    logic       rf;
    logic       rl;
    logic       cf;
    logic       cl;
    logic [1:0] lane;
  } beat_t;

  state_t                state;
  logic [ROWS_BITS-1:0]  row, h_q;
  logic [COLS_BITS-1:0]  col, w_q;
  logic [BLANK_BITS-1:0] b_q, blank_cnt;
  logic [PIX_BITS-1:0]   idx;
  logic [ADDR_BITS-1:0]  addr_q;
  beat_t                 s1, s2, s3;
  logic                  row_end, col_end;

  assign row_end   = (row == h_q - ROWS_BITS'(1));
  assign col_end   = (col == w_q - COLS_BITS'(1));
  assign rd_en     = cke;
  assign rd_regcke = cke;
  assign rd_addr   = addr_q;
  assign m_rows    = h_q;
  assign m_cols    = w_q;
  assign busy      = (state != IDLE) | s1.v | s2.v | s3.v | m_valid;

  // Raster FSM: issues one pixel address per enabled cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      idx       <= '0;
      h_q       <= '0;
      w_q       <= '0;
      b_q       <= '0;
      blank_cnt <= '0;
      addr_q    <= '0;
      s1        <= '0;
    end else if (cke) begin
      s1.v  <= 1'b0;
      s1.de <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && param_width != '0 && param_height != '0) begin
            w_q   <= param_width;
            h_q   <= param_height;
            b_q   <= param_blank;
            row   <= '0;
            col   <= '0;
            idx   <= '0;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          s1 <= '{v: 1'b1, de: 1'b1,
                  rf: (row == '0), rl: row_end,
                  cf: (col == '0), cl: col_end,
                  lane: idx[1:0]};
          addr_q <= idx[PIX_BITS-1:2];
          if (idx != PIX_MAX) idx <= idx + PIX_BITS'(1);
          if (col_end) begin
            col <= '0;
            if (row_end) begin
              state <= IDLE;
            end else begin
              row <= row + ROWS_BITS'(1);
              if (b_q != '0) begin
                blank_cnt <= b_q;
                state     <= BLANK;
              end
            end
          end else begin
            col <= col + COLS_BITS'(1);
          end
        end
        BLANK: begin
          s1.v      <= BLANK_VALID;
          blank_cnt <= blank_cnt - BLANK_BITS'(1);
          if (blank_cnt == BLANK_BITS'(1)) state <= ACTIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay line matching RAM latency, then lane select into the output beat
  always_ff @(posedge clk) begin
    if (reset) begin
      s2          <= '0;
      s3          <= '0;
      m_valid     <= 1'b0;
      m_de        <= 1'b0;
      m_row_first <= 1'b0;
      m_row_last  <= 1'b0;
      m_col_first <= 1'b0;
      m_col_last  <= 1'b0;
      m_data      <= '0;
    end else if (cke) begin
      s2          <= s1;
      s3          <= s2;
      m_valid     <= s3.v;
      m_de        <= s3.de;
      m_row_first <= s3.rf;
      m_row_last  <= s3.rl;
      m_col_first <= s3.cf;
      m_col_last  <= s3.cl;
      if (s3.de) m_data <= rd_dout[{s3.lane, 4'b0000} +: 16];
    end
  end

endmodule

// File: tb/tb_img_frame_reader.sv
// Directed bench for img_frame_reader with a 2-cycle RAM model.
// Small 64-pixel buffer so index saturation is reachable.
module tb_img_frame_reader;

  localparam int BUF = 64;
  localparam int RB  = 9;
  localparam int CB  = 10;
  localparam int BB  = 8;
  localparam int AB  = $clog2(BUF) - 2;
`ifdef IMG_FRAME_READER_BLANK_VALID_EN
  localparam int BV = 1;
`else
  localparam int BV = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cke = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic [CB-1:0] pw = '0;
  logic [RB-1:0] ph = '0;
  logic [BB-1:0] pb = '0;
  logic          rd_en, rd_regcke;
  logic [AB-1:0] rd_addr;
  logic [63:0]   rd_dout = '0;
  logic [RB-1:0] m_rows;
  logic [CB-1:0] m_cols;
  logic          m_rf, m_rl, m_cf, m_cl, m_de, m_valid;
  logic [15:0]   m_data;

  logic [63:0]   mem [0:(BUF/4)-1];
  logic [AB-1:0] a_q = '0;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  int q_v[$], q_de[$], q_d[$], q_fl[$], q_a[$], q_b[$], q_ck[$];
  int bd[$], bfl[$];
  int fb, lb, rd_bad;

  img_frame_reader #(
    .BUF_SIZE(BUF), .ROWS_BITS(RB), .COLS_BITS(CB), .BLANK_BITS(BB)
  ) dut (
    .clk(clk), .reset(reset), .cke(cke), .start(start), .busy(busy),
    .param_width(pw), .param_height(ph), .param_blank(pb),
    .rd_en(rd_en), .rd_regcke(rd_regcke), .rd_addr(rd_addr),
    .rd_dout(rd_dout), .m_rows(m_rows), .m_cols(m_cols),
    .m_row_first(m_rf), .m_row_last(m_rl),
    .m_col_first(m_cf), .m_col_last(m_cl),
    .m_de(m_de), .m_data(m_data), .m_valid(m_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) a_q <= rd_addr;
    if (rd_regcke) rd_dout <= mem[a_q];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // start pulse at index 0; cke low for 3 edges at ck_lo; extra start at st2
  task automatic run(input int n, input int ck_lo, input int st2,
                     input int rst_at);
    q_v.delete(); q_de.delete(); q_d.delete(); q_fl.delete();
    q_a.delete(); q_b.delete(); q_ck.delete();
    bd.delete(); bfl.delete();
    fb = -1; lb = -1; rd_bad = 0;
    for (int i = 0; i < n; i++) begin
      cke   = !(ck_lo >= 0 && i >= ck_lo && i < ck_lo + 3);
      start = (i == 0) || (i == st2);
      reset = (i == rst_at);
      @(posedge clk);
      #1;
      if (rd_en !== cke || rd_regcke !== cke) rd_bad++;
      q_v.push_back(int'(m_valid));
      q_de.push_back(int'(m_de));
      q_d.push_back(int'(m_data));
      q_fl.push_back(int'({m_rf, m_rl, m_cf, m_cl}));
      q_a.push_back(int'(rd_addr));
      q_b.push_back(int'(busy));
      q_ck.push_back(int'(cke));
      if (cke && m_valid && m_de) begin
        bd.push_back(int'(m_data));
        bfl.push_back(int'({m_rf, m_rl, m_cf, m_cl}));
        if (fb < 0) fb = i;
        lb = i;
      end
    end
    cke = 1'b1; start = 1'b0; reset = 1'b0;
    chk("rd_en_eq_cke", rd_bad, 0);
  endtask

  task automatic check_frame(input string tag, input int w, input int h);
    int r, c, ed, ef;
    chk({tag, "_beats"}, bd.size(), w * h);
    chk({tag, "_first_idx"}, fb, 4);
    for (int i = 0; i < bd.size() && i < w * h; i++) begin
      r  = i / w;
      c  = i % w;
      ed = (i < BUF) ? i : BUF - 1;
      ef = (r == 0 ? 8 : 0) + (r == h - 1 ? 4 : 0)
         + (c == 0 ? 2 : 0) + (c == w - 1 ? 1 : 0);
      chk($sformatf("%s_data%0d", tag, i), bd[i], ed);
      chk($sformatf("%s_flags%0d", tag, i), bfl[i], ef);
    end
    if (lb >= 0 && lb + 1 < q_b.size()) begin
      chk({tag, "_busy_last"}, q_b[lb], 1);
      chk({tag, "_busy_drop"}, q_b[lb + 1], 0);
    end else begin
      chk({tag, "_busy_window"}, lb, -2);
    end
  endtask

  initial begin
    int s;
    int ea[19] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1,
                   2, 2, 2, 2, 2, 2, 3, 3, 3};
    for (int wd = 0; wd < BUF / 4; wd++)
      for (int k = 0; k < 4; k++)
        mem[wd][16*k +: 16] = 16'(4 * wd + k);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_de", int'(m_de), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_flags", int'({m_rf, m_rl, m_cf, m_cl}), 0);
    reset = 1'b0;

    pw = 8; ph = 2; pb = 0;
    run(30, -1, -1, -1);
    chk("f8x2_busy_on", q_b[0], 1);
    check_frame("f8x2", 8, 2);
    chk("f8x2_rows", int'(m_rows), 2);
    chk("f8x2_cols", int'(m_cols), 8);

    pw = 5; ph = 3; pb = 2;
    run(30, -1, -1, -1);
    check_frame("f5x3", 5, 3);
    for (int i = 0; i < 19; i++)
      chk($sformatf("f5x3_addr%0d", i + 1), q_a[i + 1], ea[i]);
    chk("f5x3_gap9_v", q_v[9], BV);
    chk("f5x3_gap10_v", q_v[10], BV);
    chk("f5x3_gap16_v", q_v[16], BV);
    chk("f5x3_gap17_v", q_v[17], BV);
    chk("f5x3_gap_de", q_de[9] + q_de[10] + q_de[16] + q_de[17], 0);
    s = 0;
    foreach (q_v[i]) s += q_v[i];
    chk("f5x3_valid_cnt", s, 15 + 4 * BV);

    pw = 8; ph = 2; pb = 0;
    run(35, 8, -1, -1);
    check_frame("cke", 8, 2);
    for (int i = 8; i < 11; i++) begin
      chk($sformatf("cke_frz_d%0d", i), q_d[i], 3);
      chk($sformatf("cke_frz_v%0d", i), q_v[i], 1);
    end

    run(40, -1, 6, -1);
    check_frame("restart", 8, 2);

    pw = 0; ph = 2;
    run(8, -1, -1, -1);
    s = 0;
    foreach (q_b[i]) s += q_b[i] + q_v[i];
    chk("w0_idle", s, 0);

    pw = 8; ph = 2; pb = 0;
    run(30, -1, -1, 10);
    chk("rst_mid_beats", bd.size(), 6);
    if (bd.size() == 6) chk("rst_mid_last", bd[5], 5);
    s = 0;
    for (int i = 10; i < 30; i++) s += q_v[i] + q_b[i];
    chk("rst_mid_quiet", s, 0);
    run(30, -1, -1, -1);
    check_frame("after_rst", 8, 2);

    pw = 10; ph = 8; pb = 0;
    run(95, -1, -1, -1);
    check_frame("sat", 10, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
